// File: rtl/seq_det_scheduler.sv
// ---------------------------------------------------------------------------
// seq_det_scheduler
// Shares one external serial 1101 detector between two word-wide requesters.
// A word is accepted from requester A or B by round-robin arbitration. The
// detector is then cleared, the word is shifted into it MSB first, and the
// detector hits are counted. The count is returned with the requester id as
// a one-cycle done pulse.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for a request; grants combinationally when one is seen
// CLEAR  | one cycle with det_clr high; the match count and bit count reset
// SHIFT  | WORD_W cycles, one bit per cycle on det_i, det_o sampled each cycle
// REPORT | one cycle with done high; the priority pointer moves past this id
//
// Ports
//   i_clk         system clock, rising edge
//   i_rst         asynchronous reset, active high
//   i_req[1:0]    request lines, [0]=A, [1]=B
//   i_data_a/b    request words, sampled in the grant cycle
//   o_gnt[1:0]    one-hot accept pulse
//   o_busy        high whenever the FSM is not in IDLE
//   o_det_clr     detector clear, high only in CLEAR
//   o_det_i       serial bit to the detector
//   i_det_o       detector Mealy output
//   o_done        one-cycle result-valid pulse
//   o_done_id     id of the last completed word (0=A, 1=B)
//   o_match_cnt   saturating hit count, held until the next CLEAR
// ---------------------------------------------------------------------------
module seq_det_scheduler #(
   parameter int WORD_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [1:0]        i_req,
   input  logic [WORD_W-1:0] i_data_a,
   input  logic [WORD_W-1:0] i_data_b,
   output logic [1:0]        o_gnt,
   output logic              o_busy,
   output logic              o_det_clr,
   output logic              o_det_i,
   input  logic              i_det_o,
   output logic              o_done,
   output logic              o_done_id,
   output logic [CNT_W-1:0]  o_match_cnt
);

   localparam int BIT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CLEAR  = 2'd1,
      SHIFT  = 2'd2,
      REPORT = 2'd3
   } state_t;

   state_t             r_state;
   logic [WORD_W-1:0]  r_shift;
   logic [BIT_W-1:0]   r_bit;
   logic               r_id;
   logic               r_ptr;
   logic               r_det_clr;
   logic               r_det_i;
   logic               r_done;
   logic               r_done_id;
   logic [CNT_W-1:0]   r_match_cnt;
   logic [1:0]         w_gnt;

   // The grant is an accept pulse in the IDLE cycle itself, so it is decoded
   // from the state flop and the live request lines. It is forced low while
   // reset is asserted so that every output reads 0 during reset.
   always_comb begin
      w_gnt = 2'b00;
      if (r_state == IDLE && !i_rst) begin
         case (i_req)
            2'b01:   w_gnt = 2'b01;
            2'b10:   w_gnt = 2'b10;
            2'b11:   w_gnt = r_ptr ? 2'b10 : 2'b01;
            default: w_gnt = 2'b00;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_shift     <= '0;
         r_bit       <= '0;
         r_id        <= 1'b0;
         r_ptr       <= 1'b0;
         r_det_clr   <= 1'b0;
         r_det_i     <= 1'b0;
         r_done      <= 1'b0;
         r_done_id   <= 1'b0;
         r_match_cnt <= '0;
      end else begin
         r_det_clr <= 1'b0;
         r_done    <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_gnt != 2'b00) begin
                  r_id      <= w_gnt[1];
                  r_shift   <= w_gnt[1] ? i_data_b : i_data_a;
                  r_det_clr <= 1'b1;
                  r_state   <= CLEAR;
               end
            end
            CLEAR: begin
               // det_i is a flop; the MSB is staged here so it is on the
               // wire during the first SHIFT cycle.
               r_match_cnt <= '0;
               r_bit       <= '0;
               r_det_i     <= r_shift[WORD_W-1];
               r_shift     <= r_shift << 1;
               r_state     <= SHIFT;
            end
            SHIFT: begin
               if (i_det_o && (r_match_cnt != CNT_MAX)) begin
                  r_match_cnt <= r_match_cnt + 1'b1;
               end
               if (r_bit == LAST_BIT) begin
                  r_det_i   <= 1'b0;
                  r_done    <= 1'b1;
                  r_done_id <= r_id;
                  r_state   <= REPORT;
               end else begin
                  r_det_i <= r_shift[WORD_W-1];
                  r_shift <= r_shift << 1;
                  r_bit   <= r_bit + 1'b1;
               end
            end
            REPORT: begin
               r_ptr   <= ~r_id;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_gnt       = w_gnt;
   assign o_busy      = (r_state != IDLE);
   assign o_det_clr   = r_det_clr;
   assign o_det_i     = r_det_i;
   assign o_done      = r_done;
   assign o_done_id   = r_done_id;
   assign o_match_cnt = r_match_cnt;

endmodule

// File: tb/tb_seq_det_scheduler.sv
module tb_seq_det_scheduler;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [1:0]   req = 2'b00;
   logic [W-1:0] data_a = '0;
   logic [W-1:0] data_b = '0;

   logic [1:0] gnt, gnt1;
   logic       busy, det_clr, det_i, det_o, done, done_id;
   logic       busy1, det_clr1, det_i1, det_o1, done1, done_id1;
   logic [3:0] match_cnt;
   logic [0:0] match_cnt1;

   int cyc = 0;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seq_det_scheduler #(.WORD_W(W), .CNT_W(4)) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_data_a(data_a), .i_data_b(data_b),
      .o_gnt(gnt), .o_busy(busy), .o_det_clr(det_clr), .o_det_i(det_i),
      .i_det_o(det_o), .o_done(done), .o_done_id(done_id), .o_match_cnt(match_cnt)
   );

   seq_det_scheduler #(.WORD_W(W), .CNT_W(1)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_data_a(data_a), .i_data_b(data_b),
      .o_gnt(gnt1), .o_busy(busy1), .o_det_clr(det_clr1), .o_det_i(det_i1),
      .i_det_o(det_o1), .o_done(done1), .o_done_id(done_id1), .o_match_cnt(match_cnt1)
   );

   // Behavioural non-overlapping 1101 Mealy detectors, one per DUT.
   logic [1:0] ds = 2'd0;
   logic [1:0] ds1 = 2'd0;
   assign det_o  = (ds == 2'd3) && det_i;
   assign det_o1 = (ds1 == 2'd3) && det_i1;

   function automatic logic [1:0] det_next(input logic [1:0] s, input logic b);
      case (s)
         2'd0:    return b ? 2'd1 : 2'd0;
         2'd1:    return b ? 2'd2 : 2'd0;
         2'd2:    return b ? 2'd2 : 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   always @(posedge clk) begin
      ds  <= det_clr  ? 2'd0 : det_next(ds, det_i);
      ds1 <= det_clr1 ? 2'd0 : det_next(ds1, det_i1);
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Greedy left-to-right non-overlapping count of 1101 within the first n
   // bits of w, MSB first.
   function automatic int hits(input logic [W-1:0] w, input int n);
      int c = 0;
      int i = 0;
      while (i + 3 < n) begin
         if (w[W-1-i] && w[W-2-i] && !w[W-3-i] && w[W-4-i]) begin
            c++;
            i += 4;
         end else begin
            i++;
         end
      end
      return c;
   endfunction

   function automatic int sat(input int x, input int mx);
      return (x > mx) ? mx : x;
   endfunction

   // Model: age counts cycles since the grant cycle (-1 when idle).
   int           m_age = -1;
   logic [W-1:0] m_word = '0;
   int           m_id = 0;
   int           m_ptr = 0;
   int           m_hid = 0;
   int           m_pc4 = 0;
   int           m_pc1 = 0;

   always @(negedge clk) begin
      int e_gnt, e_busy, e_clr, e_di, e_done, e_id, e_c4, e_c1, k;
      if (rst) begin
         chk("rst_gnt", gnt, 0);
         chk("rst_busy", busy, 0);
         chk("rst_det_clr", det_clr, 0);
         chk("rst_det_i", det_i, 0);
         chk("rst_done", done, 0);
         chk("rst_done_id", done_id, 0);
         chk("rst_match_cnt", match_cnt, 0);
         m_age = -1; m_ptr = 0; m_hid = 0; m_pc4 = 0; m_pc1 = 0;
      end else begin
         e_gnt = 0;
         if (m_age < 0 && req != 2'b00) begin
            k = (req == 2'b11) ? m_ptr : int'(req[1]);
            e_gnt = 1 << k;
            m_id = k;
            m_word = k ? data_b : data_a;
            m_age = 0;
         end
         e_busy = (m_age >= 1);
         e_clr  = (m_age == 1);
         e_di   = (m_age >= 2 && m_age <= W + 1) ? int'(m_word[W-1-(m_age-2)]) : 0;
         e_done = (m_age == W + 2);
         e_id   = e_done ? m_id : m_hid;
         e_c4   = (m_age >= 2) ? sat(hits(m_word, m_age - 2), 15) : m_pc4;
         e_c1   = (m_age >= 2) ? sat(hits(m_word, m_age - 2), 1) : m_pc1;
         chk("gnt", gnt, e_gnt);
         chk("busy", busy, e_busy);
         chk("det_clr", det_clr, e_clr);
         chk("det_i", det_i, e_di);
         chk("done", done, e_done);
         chk("done_id", done_id, e_id);
         chk("match_cnt", match_cnt, e_c4);
         chk("match_cnt_w1", match_cnt1, e_c1);
         chk("done_w1", done1, e_done);
         if (m_age == W + 2) begin
            m_ptr = 1 - m_id;
            m_hid = m_id;
            m_pc4 = sat(hits(m_word, W), 15);
            m_pc1 = sat(hits(m_word, W), 1);
            m_age = -1;
         end else if (m_age >= 0) begin
            m_age++;
         end
      end
   end

   task automatic wait_gnt(input int lim, output int ok, output int tg, output int gv);
      ok = 0; tg = -1; gv = 0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (gnt != 2'b00) begin
            ok = 1; tg = cyc; gv = gnt;
            break;
         end
      end
   endtask

   task automatic wait_done(input int lim, output int ok, output int td);
      ok = 0; td = -1;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1; td = cyc;
            break;
         end
      end
   endtask

   task automatic pulse_rst();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
   endtask

   // One job from a single requester k; returns the grant and done cycles.
   task automatic one_job(input int k, input logic [W-1:0] w, output int tg, output int td);
      int ok, gv;
      @(posedge clk); #1;
      if (k == 0) data_a = w; else data_b = w;
      req = 2'(1 << k);
      wait_gnt(30, ok, tg, gv);
      chk("job_gnt_seen", ok, 1);
      chk("job_gnt_val", gv, 1 << k);
      @(posedge clk); #1 req = 2'b00;
      wait_done(30, ok, td);
      chk("job_done_seen", ok, 1);
   endtask

   initial begin
      int ok, tg, td, gv;
      int tgs[4];
      int gvs[4];

      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy_lit", busy, 0);
      chk("reset_cnt_lit", match_cnt, 0);
      rst = 1'b0;

      // 1: A alone, 1101_1010
      one_job(0, 8'b1101_1010, tg, td);
      chk("t1_latency", td - tg, 10);
      chk("t1_cnt", match_cnt, 1);
      chk("t1_id", done_id, 0);

      // 2: B alone, 1101_1101 then FF; narrow counter saturates at 1
      one_job(1, 8'b1101_1101, tg, td);
      chk("t2_cnt", match_cnt, 2);
      chk("t2_id", done_id, 1);
      chk("t6_cnt_w1", match_cnt1, 1);
      one_job(1, 8'hFF, tg, td);
      chk("t2_ff_cnt", match_cnt, 0);

      // 5: pointer at B, both request, reset mid-SHIFT, next grant to A
      one_job(0, 8'h0D, tg, td);
      @(posedge clk); #1;
      data_a = 8'hD0; data_b = 8'hDD; req = 2'b11;
      wait_gnt(10, ok, tg, gv);
      chk("t5_first_gnt", gv, 2);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("t5_busy_now", busy, 0);
      chk("t5_cnt_now", match_cnt, 0);
      chk("t5_det_i_now", det_i, 0);
      @(posedge clk); #1 rst = 1'b0;
      wait_gnt(5, ok, tg, gv);
      chk("t5_gnt_after_rst", gv, 1);
      @(posedge clk); #1 req = 2'b00;
      wait_done(20, ok, td);
      chk("t5_done_id", done_id, 0);
      chk("t5_cnt", match_cnt, 1);

      // 3: both held from reset -> A,B,A,B every 11 cycles
      pulse_rst();
      data_a = 8'b1101_1010; data_b = 8'b1101_1101; req = 2'b11;
      for (int i = 0; i < 4; i++) begin
         wait_gnt(20, ok, tgs[i], gvs[i]);
         chk("t3_gnt_seen", ok, 1);
      end
      @(posedge clk); #1 req = 2'b00;
      for (int i = 0; i < 4; i++) chk("t3_gnt_order", gvs[i], (i % 2 == 0) ? 1 : 2);
      for (int i = 1; i < 4; i++) chk("t3_gnt_gap", tgs[i] - tgs[i-1], 11);
      wait_done(20, ok, td);
      chk("t3_last_id", done_id, 1);

      // 4: A granted, B requests mid-SHIFT, B granted right after A's done
      @(posedge clk); #1 data_a = 8'b0110_1101; req = 2'b01;
      wait_gnt(10, ok, tg, gv);
      chk("t4_gnt_a", gv, 1);
      @(posedge clk); #1 req = 2'b00;
      repeat (3) @(posedge clk);
      #1 data_b = 8'h0D; req = 2'b10;
      wait_done(20, ok, td);
      chk("t4_a_cnt", match_cnt, 1);
      wait_gnt(5, ok, tg, gv);
      chk("t4_gnt_b", gv, 2);
      chk("t4_gnt_timing", tg - td, 1);
      @(posedge clk); #1 req = 2'b00;
      wait_done(20, ok, td);
      chk("t4_b_id", done_id, 1);
      chk("t4_b_cnt", match_cnt, 1);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

endmodule
